tcp_tx_ptr_rd_arb: RTL

//  Shares one TX pointer-memory read port (head or tail ptr array) between two requesters:

---
 rtl/tcp_tx_ptr_rd_arb.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tcp_tx_ptr_rd_arb.sv
// tcp_tx_ptr_rd_arb: round-robin arbiter that shares one TX pointer-memory read
// port between the app-side pointer tile (port 0) and the TCP TX engine
// (port 1). A small tag FIFO records which port issued each read, so that
// in-order memory responses can be routed back to the right port.

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PAYLOAD_PTR_W
`define PAYLOAD_PTR_W 16
`endif

module tcp_tx_ptr_rd_arb #(
  parameter int TAG_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        rd0_req_val,
  input  logic [`FLOW_ID_W-1:0]       rd0_req_flowid,
  output logic                        rd0_req_rdy,
  output logic                        rd0_resp_val,
  output logic [`FLOW_ID_W-1:0]       rd0_resp_flowid,
  output logic [`PAYLOAD_PTR_W:0]     rd0_resp_data,
  input  logic                        rd0_resp_rdy,

  input  logic                        rd1_req_val,
  input  logic [`FLOW_ID_W-1:0]       rd1_req_flowid,
  output logic                        rd1_req_rdy,
  output logic                        rd1_resp_val,
  output logic [`FLOW_ID_W-1:0]       rd1_resp_flowid,
  output logic [`PAYLOAD_PTR_W:0]     rd1_resp_data,
  input  logic                        rd1_resp_rdy,

  output logic                        mem_rd_req_val,
  output logic [`FLOW_ID_W-1:0]       mem_rd_req_flowid,
  input  logic                        mem_rd_req_rdy,
  input  logic                        mem_rd_resp_val,
  input  logic [`FLOW_ID_W-1:0]       mem_rd_resp_flowid,
  input  logic [`PAYLOAD_PTR_W:0]     mem_rd_resp_data,
  output logic                        mem_rd_resp_rdy,

  output logic [$clog2(TAG_DEPTH):0]  outstanding_cnt,
  output logic                        err_unexp_resp
);

  localparam int PW    = $clog2(TAG_DEPTH);
  localparam int CNT_W = PW + 1;

  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             tag_q [TAG_DEPTH];
  logic             err_q, err_d;

  logic full, empty;
  logic grant_id;
  logic push, pop;
  logic head_tag;

  assign full  = (cnt_q == CNT_W'(TAG_DEPTH));
  assign empty = (cnt_q == '0);

  // Request arbitration: lone requester wins, ties go to the round-robin favourite.
  always_comb begin
    grant_id          = 1'b0;
    rd0_req_rdy       = 1'b0;
    rd1_req_rdy       = 1'b0;
    mem_rd_req_val    = 1'b0;
    mem_rd_req_flowid = rd0_req_flowid;
    rr_d              = rr_q;
    if (rd0_req_val && rd1_req_val) begin
      grant_id = rr_q;
    end else begin
      grant_id = rd1_req_val;
    end
    mem_rd_req_val    = ~full & (rd0_req_val | rd1_req_val);
    mem_rd_req_flowid = grant_id ? rd1_req_flowid : rd0_req_flowid;
    rd0_req_rdy       = mem_rd_req_val & ~grant_id & mem_rd_req_rdy;
    rd1_req_rdy       = mem_rd_req_val &  grant_id & mem_rd_req_rdy;
    push              = mem_rd_req_val & mem_rd_req_rdy;
    if (push) begin
      rr_d = ~grant_id;
    end
  end

  assign head_tag = tag_q[rd_ptr_q];

  // Response routing: the FIFO head names the owner of the next response.
  // With no tag outstanding, responses are swallowed and flagged.
  always_comb begin
    rd0_resp_val    = 1'b0;
    rd1_resp_val    = 1'b0;
    mem_rd_resp_rdy = 1'b1;
    err_d           = err_q;
    pop             = 1'b0;
    if (!empty) begin
      rd0_resp_val    = mem_rd_resp_val & ~head_tag;
      rd1_resp_val    = mem_rd_resp_val &  head_tag;
      mem_rd_resp_rdy = head_tag ? rd1_resp_rdy : rd0_resp_rdy;
      pop             = mem_rd_resp_val & mem_rd_resp_rdy;
    end else if (mem_rd_resp_val) begin
      err_d = 1'b1;
    end
  end

  assign rd0_resp_flowid = mem_rd_resp_flowid;
  assign rd1_resp_flowid = mem_rd_resp_flowid;
  assign rd0_resp_data   = mem_rd_resp_data;
  assign rd1_resp_data   = mem_rd_resp_data;

  assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

  // Arbiter pointer, tag FIFO pointers/count and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Tag storage: one bit per in-flight read naming the issuing port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= 1'b0;
    end else if (push) begin
      tag_q[wr_ptr_q] <= grant_id;
    end
  end

  assign outstanding_cnt = cnt_q;
  assign err_unexp_resp  = err_q;

endmodule
